microsequencer: RTL and testbench

MICROSEQUENCER -- requirements
Module: microsequencer

---
 rtl/microsequencer.sv | 164 ++++++++++++++++
 tb/tb_microsequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - control-store microsequencer with return stack and MOC timeout
//
// Ports:
//   CLK      in   1   clock, all state changes on rising edge
//   CLR      in   1   asynchronous active-low reset
//   N        in   3   next-address select
//   INV      in   1   inverts the selected condition
//   MI       in   1   MOC-wait enable
//   S        in   3   condition select
//   CR       in  16   CR[7:0] target, CR[15:8] alternate / abort target
//   ENC      in   8   instruction-decoder entry address
//   MOC      in   1   memory-operation-complete
//   COND_OK  in   1   condition-field evaluation result
//   FLAGS    in   4   {N, Z, C, V}
//   IRQ      in   1   interrupt pending
//   STATE    out  8   registered current state (control-ROM address)
//   STK_ERR  out  1   sticky stack overflow/underflow flag
//   TO_ERR   out  1   sticky MOC timeout flag
module microsequencer #(
    parameter logic [7:0] RESET_STATE = 8'd0,
    parameter int         STACK_DEPTH = 4,
    parameter int         MOC_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [2:0]  N,
    input  logic        INV,
    input  logic        MI,
    input  logic [2:0]  S,
    input  logic [15:0] CR,
    input  logic [7:0]  ENC,
    input  logic        MOC,
    input  logic        COND_OK,
    input  logic [3:0]  FLAGS,
    input  logic        IRQ,
    output logic [7:0]  STATE,
    output logic        STK_ERR,
    output logic        TO_ERR
);

    // Pointer must represent 0..STACK_DEPTH inclusive; the entry index only 0..STACK_DEPTH-1.
    localparam int SP_W   = (STACK_DEPTH > 0) ? $clog2(STACK_DEPTH + 1) : 1;
    localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int WAIT_W = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;

    localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MOC_TIMEOUT - 1);

    localparam logic [2:0] N_ENC    = 3'b000;
    localparam logic [2:0] N_JMP    = 3'b001;
    localparam logic [2:0] N_CJMP   = 3'b010;
    localparam logic [2:0] N_CSEL   = 3'b011;
    localparam logic [2:0] N_INC    = 3'b100;
    localparam logic [2:0] N_CENC   = 3'b101;
    localparam logic [2:0] N_CALL   = 3'b110;
    localparam logic [2:0] N_RET    = 3'b111;

    logic [7:0]        state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              stk_err_q, stk_err_d;
    logic              to_err_q, to_err_d;

    logic [7:0] stack_q [0:(2**IDX_W)-1];

    logic [7:0]      inc;
    logic            sel;
    logic            c;
    logic            stall;
    logic            push_en;
    logic [SP_W-1:0] sp_dec;

    always_comb begin
        inc    = state_q + 8'd1;
        sp_dec = sp_q - SP_W'(1);
        stall  = MI & ~MOC;

        sel = 1'b0;
        case (S)
            3'b000:  sel = 1'b0;
            3'b001:  sel = MOC;
            3'b010:  sel = COND_OK;
            3'b011:  sel = FLAGS[2];
            3'b100:  sel = FLAGS[3];
            3'b101:  sel = FLAGS[1];
            3'b110:  sel = FLAGS[0];
            default: sel = IRQ;
        endcase
        c = sel ^ INV;

        state_d   = state_q;
        sp_d      = sp_q;
        wait_d    = '0;
        stk_err_d = stk_err_q;
        to_err_d  = to_err_q;
        push_en   = 1'b0;

        if (stall) begin
            // Stall overrides the N field entirely; only the abort path may move STATE.
            if (wait_q == WAIT_LAST) begin
                state_d  = CR[15:8];
                to_err_d = 1'b1;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end else begin
            case (N)
                N_ENC:   state_d = ENC;
                N_JMP:   state_d = CR[7:0];
                N_CJMP:  state_d = c ? CR[7:0] : inc;
                N_CSEL:  state_d = c ? CR[7:0] : CR[15:8];
                N_INC:   state_d = inc;
                N_CENC:  state_d = c ? ENC : inc;
                N_CALL: begin
                    // A call on a full stack still jumps; only the return address is lost.
                    state_d = CR[7:0];
                    if (sp_q == SP_FULL) begin
                        stk_err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                    end
                end
                default: begin
                    if (sp_q == '0) begin
                        state_d   = RESET_STATE;
                        stk_err_d = 1'b1;
                    end else begin
                        state_d = stack_q[sp_dec[IDX_W-1:0]];
                        sp_d    = sp_dec;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= RESET_STATE;
            sp_q      <= '0;
            wait_q    <= '0;
            stk_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            wait_q    <= wait_d;
            stk_err_q <= stk_err_d;
            to_err_q  <= to_err_d;
        end
    end

    // Stack contents carry no reset; only the pointer defines validity.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[sp_q[IDX_W-1:0]] <= inc;
        end
    end

    assign STATE   = state_q;
    assign STK_ERR = stk_err_q;
    assign TO_ERR  = to_err_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - scoreboard testbench for microsequencer
module tb_microsequencer;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic [2:0]  N = 3'b100;
    logic        INV = 1'b0;
    logic        MI = 1'b0;
    logic [2:0]  S = 3'b000;
    logic [15:0] CR = 16'h0000;
    logic [7:0]  ENC = 8'h00;
    logic        MOC = 1'b0;
    logic        COND_OK = 1'b0;
    logic [3:0]  FLAGS = 4'h0;
    logic        IRQ = 1'b0;
    logic [7:0]  STATE;
    logic        STK_ERR;
    logic        TO_ERR;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];

    microsequencer #(
        .RESET_STATE(8'd0),
        .STACK_DEPTH(4),
        .MOC_TIMEOUT(16)
    ) dut (
        .CLK(CLK),
        .CLR(CLR),
        .N(N),
        .INV(INV),
        .MI(MI),
        .S(S),
        .CR(CR),
        .ENC(ENC),
        .MOC(MOC),
        .COND_OK(COND_OK),
        .FLAGS(FLAGS),
        .IRQ(IRQ),
        .STATE(STATE),
        .STK_ERR(STK_ERR),
        .TO_ERR(TO_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input logic [7:0] e);
        sb.push_back(e);
    endtask

    // One clock edge; the oldest expected STATE is compared 1 time unit after it.
    task automatic tick(input string tag);
        logic [7:0] e;
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0d expected=<scoreboard empty>", tag, STATE);
        end else begin
            e = sb.pop_front();
            chk8(tag, STATE, e);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] e);
        expect_state(e);
        tick(tag);
    endtask

    task automatic jump(input logic [15:0] cr);
        N  = 3'b001;
        MI = 1'b0;
        CR = cr;
        step("jump", cr[7:0]);
    endtask

    initial begin
        // Reset held across clock edges.
        repeat (2) @(posedge CLK);
        #1;
        chk8("reset_state", STATE, 8'd0);
        chk1("reset_stk_err", STK_ERR, 1'b0);
        chk1("reset_to_err", TO_ERR, 1'b0);
        CLR = 1'b1;

        // Sequential increment and wrap.
        N = 3'b100;
        step("inc1", 8'd1);
        step("inc2", 8'd2);
        step("inc3", 8'd3);

        // Conditional jump on MOC with INV.
        N = 3'b010; S = 3'b001; INV = 1'b0; MOC = 1'b1; CR = 16'h0010;
        step("cjmp_moc1", 8'd16);
        jump(16'h0003);
        N = 3'b010; S = 3'b001; INV = 1'b0; MOC = 1'b0; CR = 16'h0010;
        step("cjmp_moc0", 8'd4);
        jump(16'h0003);
        N = 3'b010; S = 3'b001; INV = 1'b1; MOC = 1'b0; CR = 16'h0010;
        step("cjmp_inv", 8'd16);
        INV = 1'b0;

        jump(16'h00FF);
        N = 3'b100;
        step("wrap", 8'd0);

        // Decoder entry and conditional entry.
        N = 3'b000; ENC = 8'd25;
        step("enc", 8'd25);
        N = 3'b101; S = 3'b010; COND_OK = 1'b0;
        step("cenc_false", 8'd26);
        COND_OK = 1'b1;
        step("cenc_true", 8'd25);

        // Two-way select on flags and IRQ.
        N = 3'b011; CR = 16'h7788; S = 3'b011; FLAGS = 4'b0100;
        step("csel_z", 8'h88);
        S = 3'b100; FLAGS = 4'b0100;
        step("csel_n0", 8'h77);
        S = 3'b110; FLAGS = 4'b0001;
        step("csel_v", 8'h88);
        S = 3'b111; IRQ = 1'b1; INV = 1'b1;
        step("csel_irq_inv", 8'h77);
        S = 3'b000; INV = 1'b0; IRQ = 1'b0; FLAGS = 4'h0;
        step("csel_zero", 8'h77);

        // MOC timeout: 15 holds, abort on the 16th edge.
        jump(16'h2B05);
        MI = 1'b1; MOC = 1'b0; N = 3'b100;
        for (int i = 0; i < 15; i++) step("stall_hold", 8'd5);
        chk1("to_err_before", TO_ERR, 1'b0);
        step("stall_abort", 8'd43);
        chk1("to_err_set", TO_ERR, 1'b1);

        // MOC arrives after 5 stalled cycles; the counter must clear.
        for (int i = 0; i < 5; i++) step("stall_short", 8'd43);
        MOC = 1'b1;
        step("moc_done", 8'd44);
        MOC = 1'b0;
        for (int i = 0; i < 15; i++) step("stall_after_clear", 8'd44);
        MI = 1'b0;
        step("stall_release", 8'd45);
        chk1("to_err_sticky", TO_ERR, 1'b1);

        // Nested call / return.
        jump(16'h000A);
        N = 3'b110; CR = 16'h001E;
        step("call30", 8'd30);
        N = 3'b100;
        step("inc31", 8'd31);
        N = 3'b110; CR = 16'h0028;
        step("call40", 8'd40);
        N = 3'b111;
        step("ret32", 8'd32);
        step("ret11", 8'd11);
        chk1("stk_err_clean", STK_ERR, 1'b0);

        // Stall must not disturb the stack even with N=call.
        MI = 1'b1; MOC = 1'b0; N = 3'b110; CR = 16'h2B63;
        step("stall_call", 8'd11);
        MI = 1'b0;

        // Overflow at depth 4, then drain and underflow.
        N = 3'b110;
        CR = 16'h0032; step("call50", 8'd50);
        CR = 16'h003C; step("call60", 8'd60);
        CR = 16'h0046; step("call70", 8'd70);
        CR = 16'h0050; step("call80", 8'd80);
        chk1("stk_err_full", STK_ERR, 1'b0);
        CR = 16'h005A; step("call_ovf", 8'd90);
        chk1("stk_err_ovf", STK_ERR, 1'b1);
        N = 3'b111;
        step("ret71", 8'd71);
        step("ret61", 8'd61);
        step("ret51", 8'd51);
        step("ret12", 8'd12);
        step("ret_empty", 8'd0);
        chk1("stk_err_sticky", STK_ERR, 1'b1);

        // Async reset mid-stall, then a full-length timeout.
        jump(16'h2B09);
        MI = 1'b1; MOC = 1'b0; N = 3'b100;
        for (int i = 0; i < 7; i++) step("stall_pre_reset", 8'd9);
        CLR = 1'b0;
        #2;
        chk8("async_reset_state", STATE, 8'd0);
        chk1("async_reset_stk_err", STK_ERR, 1'b0);
        chk1("async_reset_to_err", TO_ERR, 1'b0);
        CLR = 1'b1;
        for (int i = 0; i < 15; i++) step("stall_post_reset", 8'd0);
        chk1("to_err_post_reset", TO_ERR, 1'b0);
        step("abort_post_reset", 8'd43);
        chk1("to_err_post_abort", TO_ERR, 1'b1);
        MI = 1'b0;

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
